// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
// The slave modport is the adder side; master is the producer/consumer side.
interface adder_pipe_if #(
  parameter int unsigned W = 8
);
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [1:0]   mode_i;
  logic         acc_clr_i;
  logic [W-1:0] sum_o;
  logic         ovf_o;
  logic         is_odd_o;
  logic         valid_o;
  logic         ready_i;

  modport slave (
    input  valid_i, a_i, b_i, mode_i, acc_clr_i, ready_i,
    output ready_o, sum_o, ovf_o, is_odd_o, valid_o
  );

  modport master (
    output valid_i, a_i, b_i, mode_i, acc_clr_i, ready_i,
    input  ready_o, sum_o, ovf_o, is_odd_o, valid_o
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined adder with wrap/saturate/subtract/accumulate modes and a global-stall
// valid/ready pipeline of LAT register stages.
module adder_pipe #(
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 2
) (
  input logic        clk,
  input logic        rst_n,
  adder_pipe_if.slave bus
);

  logic         adv;
  logic         xfer;
  logic [W-1:0] acc_q;
  logic [W-1:0] acc_base;
  logic [W:0]   add_s;
  logic [W:0]   sub_s;
  logic [W:0]   acc_s;
  logic [W-1:0] res_sum;
  logic         res_ovf;

  logic [W-1:0] sum_q [LAT];
  logic         ovf_q [LAT];
  logic         vld_q [LAT];

  assign adv         = bus.ready_i | ~vld_q[LAT-1];
  assign xfer        = bus.valid_i & adv;
  assign bus.ready_o = adv;

  // A coincident clear makes the accumulate start from zero.
  assign acc_base = bus.acc_clr_i ? '0 : acc_q;
  assign add_s    = {1'b0, bus.a_i} + {1'b0, bus.b_i};
  assign sub_s    = {1'b0, bus.a_i} - {1'b0, bus.b_i};
  assign acc_s    = {1'b0, acc_base} + {1'b0, bus.a_i};

  always_comb begin
    res_sum = add_s[W-1:0];
    res_ovf = add_s[W];
    unique case (bus.mode_i)
      2'b00: begin
        res_sum = add_s[W-1:0];
        res_ovf = add_s[W];
      end
      2'b01: begin
        res_sum = add_s[W] ? '1 : add_s[W-1:0];
        res_ovf = add_s[W];
      end
      2'b10: begin
        res_sum = sub_s[W-1:0];
        res_ovf = sub_s[W];
      end
      2'b11: begin
        res_sum = acc_s[W-1:0];
        res_ovf = acc_s[W];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (xfer && bus.mode_i == 2'b11) begin
      acc_q <= acc_s[W-1:0];
    end else if (bus.acc_clr_i) begin
      acc_q <= '0;
    end
  end

  // Data only moves with a valid beat so outputs hold the last result across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        sum_q[i] <= '0;
        ovf_q[i] <= 1'b0;
        vld_q[i] <= 1'b0;
      end
    end else if (adv) begin
      vld_q[0] <= xfer;
      if (xfer) begin
        sum_q[0] <= res_sum;
        ovf_q[0] <= res_ovf;
      end
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          sum_q[i] <= sum_q[i-1];
          ovf_q[i] <= ovf_q[i-1];
        end
      end
    end
  end

  assign bus.sum_o    = sum_q[LAT-1];
  assign bus.ovf_o    = ovf_q[LAT-1];
  assign bus.is_odd_o = sum_q[LAT-1][0];
  assign bus.valid_o  = vld_q[LAT-1];

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: W=8/LAT=2 main instance plus W=16 LAT=1 and LAT=4.
module tb_adder_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_pipe_if #(.W(8))  bus8 ();
  adder_pipe_if #(.W(16)) bus1 ();
  adder_pipe_if #(.W(16)) bus4 ();

  adder_pipe #(.W(8),  .LAT(2)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  adder_pipe #(.W(16), .LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  adder_pipe #(.W(16), .LAT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  typedef struct {
    int sum;
    int ovf;
  } exp_t;

  exp_t sb[$];
  int   model_acc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   rand_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on 8-bit operands.
  function automatic exp_t model(input int a, input int b, input int m, input bit clr);
    exp_t e;
    int   s;
    if (clr) model_acc = 0;
    case (m)
      0: begin
        s = a + b;
        e.sum = s % 256;
        e.ovf = (s > 255);
      end
      1: begin
        s = a + b;
        e.sum = (s > 255) ? 255 : s;
        e.ovf = (s > 255);
      end
      2: begin
        e.sum = (a - b + 256) % 256;
        e.ovf = (a < b);
      end
      default: begin
        s = model_acc + a;
        e.sum = s % 256;
        e.ovf = (s > 255);
        model_acc = e.sum;
      end
    endcase
    return e;
  endfunction

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus8.valid_o && bus8.ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got sum=%0d, expected no output", bus8.sum_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", int'(bus8.sum_o), e.sum);
        chk("ovf", int'(bus8.ovf_o), e.ovf);
        chk("is_odd", int'(bus8.is_odd_o), e.sum % 2);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int a, input int b, input int m, input bit clr = 1'b0);
    int n = 0;
    bus8.valid_i   = 1'b1;
    bus8.a_i       = 8'(a);
    bus8.b_i       = 8'(b);
    bus8.mode_i    = 2'(m);
    bus8.acc_clr_i = clr;
    @(negedge clk);
    while (!bus8.ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept", int'(bus8.ready_o), 1);
    if (bus8.ready_o) sb.push_back(model(a, b, m, clr));
    @(posedge clk);
    #1;
    bus8.valid_i   = 1'b0;
    bus8.acc_clr_i = 1'b0;
  endtask

  task automatic clear_acc();
    bus8.acc_clr_i = 1'b1;
    model_acc = 0;
    @(posedge clk);
    #1;
    bus8.acc_clr_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run16(input int a, input int b, input int m, input int es, input int eo);
    int lat1 = 0;
    int lat4 = 0;
    bus1.valid_i = 1'b1; bus1.a_i = 16'(a); bus1.b_i = 16'(b); bus1.mode_i = 2'(m);
    bus4.valid_i = 1'b1; bus4.a_i = 16'(a); bus4.b_i = 16'(b); bus4.mode_i = 2'(m);
    @(negedge clk);
    chk("w16_ready_lat1", int'(bus1.ready_o), 1);
    chk("w16_ready_lat4", int'(bus4.ready_o), 1);
    @(posedge clk);
    #1;
    bus1.valid_i = 1'b0;
    bus4.valid_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (bus1.valid_o && lat1 == 0) begin
        lat1 = k;
        chk("w16_sum_lat1", int'(bus1.sum_o), es);
        chk("w16_ovf_lat1", int'(bus1.ovf_o), eo);
      end
      if (bus4.valid_o && lat4 == 0) begin
        lat4 = k;
        chk("w16_sum_lat4", int'(bus4.sum_o), es);
        chk("w16_ovf_lat4", int'(bus4.ovf_o), eo);
      end
      @(posedge clk);
      #1;
    end
    chk("latency_lat1", lat1, 1);
    chk("latency_lat4", lat4, 4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus8.valid_i = 0; bus8.a_i = 0; bus8.b_i = 0; bus8.mode_i = 0;
    bus8.acc_clr_i = 0; bus8.ready_i = 1;
    bus1.valid_i = 0; bus1.a_i = 0; bus1.b_i = 0; bus1.mode_i = 0;
    bus1.acc_clr_i = 0; bus1.ready_i = 1;
    bus4.valid_i = 0; bus4.a_i = 0; bus4.b_i = 0; bus4.mode_i = 0;
    bus4.acc_clr_i = 0; bus4.ready_i = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    chk("reset_valid", int'(bus8.valid_o), 0);
    chk("reset_sum", int'(bus8.sum_o), 0);
    chk("reset_ovf", int'(bus8.ovf_o), 0);
    chk("reset_odd", int'(bus8.is_odd_o), 0);
    chk("reset_ready", int'(bus8.ready_o), 1);

    // Latency: result visible after edge N+LAT-1
    send(5, 6, 0);
    chk("lat_first_early", int'(bus8.valid_o), 0);
    @(posedge clk);
    #1;
    chk("lat_first_valid", int'(bus8.valid_o), 1);
    chk("lat_first_sum", int'(bus8.sum_o), 11);
    send(1, 1, 0);
    chk("lat_second_early", int'(bus8.valid_o), 0);
    @(posedge clk);
    #1;
    chk("lat_second_valid", int'(bus8.valid_o), 1);
    chk("lat_second_sum", int'(bus8.sum_o), 2);
    drain();

    // Modes
    send(200, 100, 0);
    send(200, 100, 1);
    send(3, 5, 2);
    send(8, 3, 2);
    send(255, 255, 1);
    send(0, 0, 2);
    drain();

    // Accumulate, including a clear coincident with a mode-11 transfer
    clear_acc();
    send(10, $urandom % 256, 3);
    send(20, $urandom % 256, 3);
    send(30, $urandom % 256, 3);
    send(250, $urandom % 256, 3);
    send(7, $urandom % 256, 3, 1'b1);
    drain();

    // Backpressure: stall three cycles as soon as the first result appears
    fork
      begin
        send(1, 1, 0);
        send(2, 2, 0);
        send(3, 3, 0);
      end
      begin
        int n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!bus8.valid_o && n < 20);
        chk("bp_first_valid", int'(bus8.valid_o), 1);
        bus8.ready_i = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_ready_low", int'(bus8.ready_o), 0);
          chk("bp_sum_hold", int'(bus8.sum_o), 2);
          chk("bp_valid_hold", int'(bus8.valid_o), 1);
          @(posedge clk);
          #1;
        end
        bus8.ready_i = 1'b1;
      end
    join
    drain();

    // Mid-flight asynchronous reset
    send(9, 9, 0);
    send(4, 4, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(bus8.valid_o), 0);
    chk("rst_sum", int'(bus8.sum_o), 0);
    chk("rst_ovf", int'(bus8.ovf_o), 0);
    chk("rst_odd", int'(bus8.is_odd_o), 0);
    sb.delete();
    model_acc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_stale", int'(bus8.valid_o), 0);
    send(5, 0, 3);
    drain();

    // Randomised traffic with random backpressure and occasional clears
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send($urandom % 256, $urandom % 256, $urandom % 4, ($urandom % 8) == 0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus8.ready_i = ($urandom % 4) != 0;
        end
      end
    join
    bus8.ready_i = 1'b1;
    drain();

    // W=16 at LAT=1 and LAT=4
    run16(65535, 1, 0, 0, 1);
    run16(65535, 1, 1, 65535, 1);
    run16(0, 1, 2, 65535, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
